// File: rtl/bsg_chip_io_link_mux.sv
// bsg_chip_io_link_mux
//
// Merges num_ch_p BedRock I/O source channels onto one mem_fwd link and
// routes the mem_rev responses back to their originating channel.
// Messages are granted whole in round-robin order. Each grant records
// its channel index in an in-order tracking FIFO. The head of that FIFO
// steers the reverse beats, and a response's last beat retires the entry.
//
// FSM states:
//   state  | meaning
//   -------+-----------------------------------------------------------
//   e_idle | no message in flight; arbitrate, outputs quiet (bubble)
//   e_busy | granted channel passes straight through to mem_fwd
//
// Ports:
//   clk_i, reset_n_i              clock, async active-low reset
//   fwd_*_i / fwd_ready_and_o     per-channel forward requests
//   mem_fwd_*_o / _ready_and_i    merged forward link
//   mem_rev_*_i / _ready_and_o    merged reverse link
//   rev_*_o / rev_ready_and_i     per-channel reverse responses
//   outstanding_o                 in-flight request count

module bsg_chip_io_link_mux #(
    parameter int num_ch_p     = 4,
    parameter int hdr_width_p  = 64,
    parameter int data_width_p = 64,
    parameter int track_els_p  = 8,
    localparam int ch_w_lp     = $clog2(num_ch_p),
    localparam int cnt_w_lp    = $clog2(track_els_p + 1),
    localparam int ptr_w_lp    = $clog2(track_els_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic [num_ch_p-1:0][hdr_width_p-1:0]   fwd_header_i,
    input  logic [num_ch_p-1:0][data_width_p-1:0]  fwd_data_i,
    input  logic [num_ch_p-1:0]                    fwd_v_i,
    input  logic [num_ch_p-1:0]                    fwd_last_i,
    output logic [num_ch_p-1:0]                    fwd_ready_and_o,

    output logic [hdr_width_p-1:0]                 mem_fwd_header_o,
    output logic [data_width_p-1:0]                mem_fwd_data_o,
    output logic                                   mem_fwd_v_o,
    output logic                                   mem_fwd_last_o,
    input  logic                                   mem_fwd_ready_and_i,

    input  logic [hdr_width_p-1:0]                 mem_rev_header_i,
    input  logic [data_width_p-1:0]                mem_rev_data_i,
    input  logic                                   mem_rev_v_i,
    input  logic                                   mem_rev_last_i,
    output logic                                   mem_rev_ready_and_o,

    output logic [num_ch_p-1:0][hdr_width_p-1:0]   rev_header_o,
    output logic [num_ch_p-1:0][data_width_p-1:0]  rev_data_o,
    output logic [num_ch_p-1:0]                    rev_v_o,
    output logic [num_ch_p-1:0]                    rev_last_o,
    input  logic [num_ch_p-1:0]                    rev_ready_and_i,

    output logic [cnt_w_lp-1:0]                    outstanding_o
);

    typedef enum logic {e_idle, e_busy} state_e;

    state_e                state_r, state_n;
    logic [ch_w_lp-1:0]    grant_r, grant_n;
    logic [ch_w_lp-1:0]    rr_ptr_r, rr_ptr_n;
    logic [ch_w_lp-1:0]    arb_idx;
    logic                  arb_found;

    logic [ch_w_lp-1:0]    track_mem [track_els_p];
    logic [ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0]   count_r;
    logic [ch_w_lp-1:0]    head;
    logic                  full, empty, push, pop, fwd_accept;

    assign full  = (count_r == cnt_w_lp'(track_els_p));
    assign empty = (count_r == '0);
    assign head  = track_mem[rd_ptr_r];

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int                 idx;
        logic [ch_w_lp-1:0] cand;
        idx       = 0;
        cand      = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < num_ch_p; i++) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= num_ch_p) idx = idx - num_ch_p;
            cand = ch_w_lp'(idx);
            if (!arb_found && fwd_v_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign push       = (state_r == e_idle) && arb_found && !full;
    assign fwd_accept = (state_r == e_busy) && fwd_v_i[grant_r] && mem_fwd_ready_and_i;
    assign pop        = !empty && mem_rev_v_i && rev_ready_and_i[head] && mem_rev_last_i;

    always_comb begin
        state_n         = state_r;
        grant_n         = grant_r;
        rr_ptr_n        = rr_ptr_r;
        mem_fwd_v_o     = 1'b0;
        fwd_ready_and_o = '0;
        case (state_r)
            e_idle: begin
                if (push) begin
                    grant_n = arb_idx;
                    state_n = e_busy;
                end
            end
            e_busy: begin
                mem_fwd_v_o              = fwd_v_i[grant_r];
                fwd_ready_and_o[grant_r] = mem_fwd_ready_and_i;
                if (fwd_accept && fwd_last_i[grant_r]) begin
                    state_n  = e_idle;
                    rr_ptr_n = (grant_r == ch_w_lp'(num_ch_p - 1)) ? '0 : grant_r + ch_w_lp'(1);
                end
            end
            default: state_n = e_idle;
        endcase
    end

    // Payload follows the grant; only mem_fwd_v_o qualifies it.
    assign mem_fwd_header_o = fwd_header_i[grant_r];
    assign mem_fwd_data_o   = fwd_data_i[grant_r];
    assign mem_fwd_last_o   = fwd_last_i[grant_r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_idle;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            state_r  <= state_n;
            grant_r  <= grant_n;
            rr_ptr_r <= rr_ptr_n;
            if (push) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry contents need no reset; validity lives in the pointers/count.
    always_ff @(posedge clk_i) begin
        if (push) track_mem[wr_ptr_r] <= arb_idx;
    end

    // Responses stall, never drop, when nothing is outstanding.
    always_comb begin
        rev_v_o             = '0;
        mem_rev_ready_and_o = 1'b0;
        if (!empty) begin
            rev_v_o[head]       = mem_rev_v_i;
            mem_rev_ready_and_o = rev_ready_and_i[head];
        end
    end

    assign rev_header_o  = {num_ch_p{mem_rev_header_i}};
    assign rev_data_o    = {num_ch_p{mem_rev_data_i}};
    assign rev_last_o    = {num_ch_p{mem_rev_last_i}};
    assign outstanding_o = count_r;

endmodule

// File: tb/tb_bsg_chip_io_link_mux.sv
module tb_bsg_chip_io_link_mux;

    localparam int NCH = 4;
    localparam int HW  = 16;
    localparam int DW  = 16;
    localparam int TE  = 8;
    localparam int CW  = $clog2(TE + 1);
    localparam int BUDGET = 200;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;

    logic [NCH-1:0][HW-1:0] fwd_header_i;
    logic [NCH-1:0][DW-1:0] fwd_data_i;
    logic [NCH-1:0]         fwd_v_i;
    logic [NCH-1:0]         fwd_last_i;
    logic [NCH-1:0]         fwd_ready_and_o;
    logic [HW-1:0]          mem_fwd_header_o;
    logic [DW-1:0]          mem_fwd_data_o;
    logic                   mem_fwd_v_o;
    logic                   mem_fwd_last_o;
    logic                   mem_fwd_ready_and_i;
    logic [HW-1:0]          mem_rev_header_i;
    logic [DW-1:0]          mem_rev_data_i;
    logic                   mem_rev_v_i;
    logic                   mem_rev_last_i;
    logic                   mem_rev_ready_and_o;
    logic [NCH-1:0][HW-1:0] rev_header_o;
    logic [NCH-1:0][DW-1:0] rev_data_o;
    logic [NCH-1:0]         rev_v_o;
    logic [NCH-1:0]         rev_last_o;
    logic [NCH-1:0]         rev_ready_and_i;
    logic [CW-1:0]          outstanding_o;

    // per-channel drivers, kept separate so forked senders never share a variable
    logic [HW-1:0] drv_hdr  [NCH];
    logic [DW-1:0] drv_data [NCH];
    logic          drv_v    [NCH];
    logic          drv_last [NCH];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            fwd_header_i[c] = drv_hdr[c];
            fwd_data_i[c]   = drv_data[c];
            fwd_v_i[c]      = drv_v[c];
            fwd_last_i[c]   = drv_last[c];
        end
    end

    bsg_chip_io_link_mux #(
        .num_ch_p(NCH), .hdr_width_p(HW), .data_width_p(DW), .track_els_p(TE)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .fwd_header_i(fwd_header_i), .fwd_data_i(fwd_data_i), .fwd_v_i(fwd_v_i),
        .fwd_last_i(fwd_last_i), .fwd_ready_and_o(fwd_ready_and_o),
        .mem_fwd_header_o(mem_fwd_header_o), .mem_fwd_data_o(mem_fwd_data_o),
        .mem_fwd_v_o(mem_fwd_v_o), .mem_fwd_last_o(mem_fwd_last_o),
        .mem_fwd_ready_and_i(mem_fwd_ready_and_i),
        .mem_rev_header_i(mem_rev_header_i), .mem_rev_data_i(mem_rev_data_i),
        .mem_rev_v_i(mem_rev_v_i), .mem_rev_last_i(mem_rev_last_i),
        .mem_rev_ready_and_o(mem_rev_ready_and_o),
        .rev_header_o(rev_header_o), .rev_data_o(rev_data_o), .rev_v_o(rev_v_o),
        .rev_last_o(rev_last_o), .rev_ready_and_i(rev_ready_and_i),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            ch;
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t fwd_q[$];
    beat_t rev_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(ref beat_t q[$], input int ch, input logic [HW-1:0] hdr,
                             input logic [DW-1:0] data, input logic last);
        beat_t e;
        e.ch = ch; e.hdr = hdr; e.data = data; e.last = last;
        q.push_back(e);
    endtask

    task automatic exp_fwd(input int ch, input int nb, input logic [15:0] tag);
        for (int b = 0; b < nb; b++)
            push_beat(fwd_q, ch, tag, tag + DW'(b), (b == nb - 1));
    endtask

    task automatic exp_rev(input int ch, input int nb, input logic [15:0] tag);
        for (int b = 0; b < nb; b++)
            push_beat(rev_q, ch, tag, tag + DW'(b), (b == nb - 1));
    endtask

    task automatic send_msg(input int ch, input int nb, input logic [15:0] tag);
        for (int b = 0; b < nb; b++) begin
            int cyc;
            drv_v[ch]    = 1'b1;
            drv_hdr[ch]  = tag;
            drv_data[ch] = tag + DW'(b);
            drv_last[ch] = (b == nb - 1);
            cyc = 0;
            do begin
                @(negedge clk_i);
                cyc++;
            end while (!fwd_ready_and_o[ch] && cyc < BUDGET);
            if (!fwd_ready_and_o[ch]) begin
                checks++; errors++;
                $display("FAIL fwd_timeout ch=%0d beat=%0d actual=no_ready required=ready", ch, b);
            end
            @(posedge clk_i); #1;
        end
        drv_v[ch]    = 1'b0;
        drv_last[ch] = 1'b0;
    endtask

    task automatic send_rev(input int nb, input logic [15:0] tag);
        for (int b = 0; b < nb; b++) begin
            int cyc;
            mem_rev_v_i      = 1'b1;
            mem_rev_header_i = tag;
            mem_rev_data_i   = tag + DW'(b);
            mem_rev_last_i   = (b == nb - 1);
            cyc = 0;
            do begin
                @(negedge clk_i);
                cyc++;
            end while (!mem_rev_ready_and_o && cyc < BUDGET);
            if (!mem_rev_ready_and_o) begin
                checks++; errors++;
                $display("FAIL rev_timeout beat=%0d actual=no_ready required=ready", b);
            end
            @(posedge clk_i); #1;
        end
        mem_rev_v_i    = 1'b0;
        mem_rev_last_i = 1'b0;
    endtask

    // scoreboard monitor: every accepted beat must match the queue head
    always @(negedge clk_i) begin
        beat_t e;
        if (reset_n_i && mem_fwd_v_o && mem_fwd_ready_and_i) begin
            checks++;
            if (fwd_q.size() == 0) begin
                errors++;
                $display("FAIL fwd_unexpected actual_hdr=%0h required=none", mem_fwd_header_o);
            end else begin
                e = fwd_q.pop_front();
                if (mem_fwd_header_o !== e.hdr || mem_fwd_data_o !== e.data ||
                    mem_fwd_last_o !== e.last || fwd_ready_and_o !== (4'b1 << e.ch)) begin
                    errors++;
                    $display("FAIL fwd_beat actual hdr=%0h data=%0h last=%0b rdy=%b required hdr=%0h data=%0h last=%0b ch=%0d",
                             mem_fwd_header_o, mem_fwd_data_o, mem_fwd_last_o, fwd_ready_and_o,
                             e.hdr, e.data, e.last, e.ch);
                end
            end
        end
        if (reset_n_i && mem_rev_v_i && mem_rev_ready_and_o) begin
            checks++;
            if (rev_q.size() == 0) begin
                errors++;
                $display("FAIL rev_unexpected actual_v=%b required=none", rev_v_o);
            end else begin
                e = rev_q.pop_front();
                if (rev_v_o !== (4'b1 << e.ch) || rev_data_o[e.ch] !== e.data ||
                    rev_header_o[e.ch] !== e.hdr || rev_last_o[e.ch] !== e.last ||
                    rev_data_o[(e.ch + 1) % NCH] !== e.data) begin
                    errors++;
                    $display("FAIL rev_beat actual v=%b data=%0h last=%0b required ch=%0d data=%0h last=%0b",
                             rev_v_o, rev_data_o[e.ch], rev_last_o[e.ch], e.ch, e.data, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t;
        for (int c = 0; c < NCH; c++) begin
            drv_hdr[c] = '0; drv_data[c] = '0; drv_v[c] = 1'b1; drv_last[c] = 1'b0;
        end
        mem_fwd_ready_and_i = 1'b1;
        mem_rev_header_i = '0; mem_rev_data_i = '0;
        mem_rev_v_i = 1'b1; mem_rev_last_i = 1'b1;
        rev_ready_and_i = '1;

        // reset with every input asserted
        repeat (2) @(negedge clk_i);
        chk("rst_mem_fwd_v", mem_fwd_v_o, 0);
        chk("rst_fwd_ready", fwd_ready_and_o, 0);
        chk("rst_mem_rev_ready", mem_rev_ready_and_o, 0);
        chk("rst_rev_v", rev_v_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        for (int c = 0; c < NCH; c++) drv_v[c] = 1'b0;
        mem_rev_v_i = 1'b0; mem_rev_last_i = 1'b0;
        @(posedge clk_i); #1 reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // ch0 and ch2 request together
        exp_fwd(0, 1, 16'h0A00);
        exp_fwd(2, 1, 16'h2A00);
        fork
            send_msg(0, 1, 16'h0A00);
            send_msg(2, 1, 16'h2A00);
            begin
                @(negedge clk_i); chk("a_out0", outstanding_o, 0);
                @(negedge clk_i); chk("a_out1", outstanding_o, 1);
                @(negedge clk_i); chk("a_out1b", outstanding_o, 1);
                @(negedge clk_i); chk("a_out2", outstanding_o, 2);
            end
        join
        exp_rev(0, 1, 16'h5000);
        exp_rev(2, 1, 16'h5200);
        send_rev(1, 16'h5000);
        send_rev(1, 16'h5200);
        chk("a_drained", outstanding_o, 0);

        // ch1 4-beat burst while ch0 stays valid
        exp_fwd(0, 1, 16'h0B00);
        send_msg(0, 1, 16'h0B00);
        exp_fwd(1, 4, 16'h1B00);
        exp_fwd(0, 1, 16'h0B10);
        fork
            send_msg(1, 4, 16'h1B00);
            send_msg(0, 1, 16'h0B10);
            begin
                @(negedge clk_i);
                for (int b = 0; b < 4; b++) begin
                    @(negedge clk_i);
                    chk("b_burst_contig", {mem_fwd_v_o, mem_fwd_data_o}, {1'b1, 16'h1B00 + 16'(b)});
                end
                @(negedge clk_i); chk("b_bubble", mem_fwd_v_o, 0);
                @(negedge clk_i); chk("b_ch0_after", {mem_fwd_v_o, mem_fwd_header_o}, {1'b1, 16'h0B10});
            end
        join
        exp_rev(0, 1, 16'h6000);
        exp_rev(1, 2, 16'h6100);
        exp_rev(0, 1, 16'h6200);
        send_rev(1, 16'h6000);
        send_rev(2, 16'h6100);
        send_rev(1, 16'h6200);
        chk("b_drained", outstanding_o, 0);

        // fill tracking, 9th request stalls until one pop
        for (int i = 0; i < TE; i++) begin
            t = 16'((i % NCH) * 4096 + 16'h0C00 + i);
            exp_fwd(i % NCH, 1, t);
            send_msg(i % NCH, 1, t);
        end
        chk("c_full", outstanding_o, TE);
        exp_fwd(3, 1, 16'h3C08);
        fork
            send_msg(3, 1, 16'h3C08);
            begin
                repeat (4) @(negedge clk_i);
                chk("c_stall_ready", fwd_ready_and_o, 0);
                chk("c_stall_v", mem_fwd_v_o, 0);
                chk("c_stall_out", outstanding_o, TE);
                @(posedge clk_i); #1;
                exp_rev(0, 1, 16'h7000);
                send_rev(1, 16'h7000);
            end
        join
        chk("c_refilled", outstanding_o, TE);
        for (int k = 1; k <= TE; k++) begin
            int ch;
            ch = (k == TE) ? 3 : (k % NCH);
            t = 16'(16'h7000 + k);
            exp_rev(ch, 1, t);
            send_rev(1, t);
        end
        chk("c_drained", outstanding_o, 0);

        // ch3 then ch1; responses route in order, ch3 stall visible
        exp_fwd(3, 1, 16'h3D00);
        send_msg(3, 1, 16'h3D00);
        exp_fwd(1, 1, 16'h1D00);
        send_msg(1, 1, 16'h1D00);
        exp_rev(3, 1, 16'h8300);
        rev_ready_and_i[3] = 1'b0;
        fork
            send_rev(1, 16'h8300);
            begin
                @(negedge clk_i);
                chk("d_route_ch3", rev_v_o, 4'b1000);
                chk("d_stall_ready", mem_rev_ready_and_o, 0);
                @(negedge clk_i);
                chk("d_stall_ready2", mem_rev_ready_and_o, 0);
                @(posedge clk_i); #1 rev_ready_and_i[3] = 1'b1;
            end
        join
        exp_rev(1, 1, 16'h8100);
        send_rev(1, 16'h8100);

        // stray response with tracking empty
        mem_rev_v_i = 1'b1; mem_rev_last_i = 1'b1; mem_rev_data_i = 16'hDEAD;
        repeat (3) begin
            @(negedge clk_i);
            chk("e_stray_ready", mem_rev_ready_and_o, 0);
            chk("e_stray_v", rev_v_o, 0);
        end
        @(posedge clk_i); #1 mem_rev_v_i = 1'b0; mem_rev_last_i = 1'b0;

        // reset in the middle of a ch1 burst
        push_beat(fwd_q, 1, 16'h1F00, 16'h1F00, 1'b0);
        push_beat(fwd_q, 1, 16'h1F00, 16'h1F01, 1'b0);
        drv_v[1] = 1'b1; drv_hdr[1] = 16'h1F00; drv_data[1] = 16'h1F00; drv_last[1] = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #1 drv_data[1] = 16'h1F01;
        @(posedge clk_i); #1 drv_data[1] = 16'h1F02;
        #2 reset_n_i = 1'b0;
        #1;
        chk("f_rst_fwd_v", mem_fwd_v_o, 0);
        chk("f_rst_fwd_ready", fwd_ready_and_o, 0);
        chk("f_rst_out", outstanding_o, 0);
        chk("f_rst_rev_ready", mem_rev_ready_and_o, 0);
        drv_v[1] = 1'b0;
        @(posedge clk_i); #1 reset_n_i = 1'b1;
        exp_fwd(1, 1, 16'h1F10);
        exp_fwd(3, 1, 16'h3F10);
        fork
            send_msg(1, 1, 16'h1F10);
            send_msg(3, 1, 16'h3F10);
        join
        chk("f_out2", outstanding_o, 2);
        exp_rev(1, 1, 16'h9100);
        exp_rev(3, 1, 16'h9300);
        send_rev(1, 16'h9100);
        send_rev(1, 16'h9300);
        chk("f_drained", outstanding_o, 0);

        repeat (2) @(negedge clk_i);
        chk("fwd_q_empty", fwd_q.size(), 0);
        chk("rev_q_empty", rev_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
